// File: rtl/inst_mem_loader.sv
// Byte-serial instruction loader: debounced button enters a 32-bit word byte by byte, then writes it to RAM port A.
// Optional INST_LOADER_WRAP_EN: address wraps to 0 after the last word instead of saturating into FULL.
module inst_mem_loader #(
   parameter int STAGE  = 10,
   parameter int ADDR_W = 6
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Button,
   input  logic [7:0]        Switch,
   output logic              wea,
   output logic [ADDR_W-1:0] addra,
   output logic [31:0]       dina,
   output logic [1:0]        byte_cnt,
   output logic              full
);

   typedef enum logic [1:0] {
      COLLECT,
      WRITE,
      FULL
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [STAGE-1:0]  r_chain;
   logic              r_deb;
   logic              r_deb_q;
   logic              w_press;
   logic              w_capture;
   logic [ADDR_W-1:0] r_addra;
   logic [31:0]       r_dina;
   logic [1:0]        r_byte_cnt;

   // Hysteresis: deb only flips once the older STAGE-1 samples all agree.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_chain <= '0;
         r_deb   <= 1'b0;
         r_deb_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values of the others.
         r_chain <= {r_chain[STAGE-2:0], Button};
         if (&r_chain[STAGE-1:1])
            r_deb <= 1'b1;
         else if (~|r_chain[STAGE-1:1])
            r_deb <= 1'b0;
         r_deb_q <= r_deb;
      end
   end

   assign w_press = r_deb & ~r_deb_q;

`ifndef INST_LOADER_WRAP_EN
   logic w_last_addr;
   assign w_last_addr = (r_addra == {ADDR_W{1'b1}});
`endif

   always_ff @(posedge Clk) begin
      if (Rst) r_state <= COLLECT;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: every output gets a default first so no path through the case can infer a latch.
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      wea         = 1'b0;
      full        = 1'b0;
      case (r_state)
         COLLECT: begin
            if (w_press) begin
               w_capture = 1'b1;
               if (r_byte_cnt == 2'd3) w_state_nxt = WRITE;
            end
         end
         WRITE: begin
            wea = 1'b1;
`ifdef INST_LOADER_WRAP_EN
            w_state_nxt = COLLECT;
`else
            w_state_nxt = w_last_addr ? FULL : COLLECT;
`endif
         end
         FULL: begin
`ifndef INST_LOADER_WRAP_EN
            full = 1'b1;
`endif
         end
         default: w_state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge Clk) begin
      // NOTE: datapath registers are reset too, so a reset mid-word leaves no stale partial word visible.
      if (Rst) begin
         r_addra    <= '0;
         r_dina     <= '0;
         r_byte_cnt <= 2'd0;
      end else begin
         if (w_capture) begin
            r_dina[{r_byte_cnt, 3'b000} +: 8] <= Switch;
            r_byte_cnt                        <= r_byte_cnt + 2'd1;
         end
         if (r_state == WRITE) begin
`ifdef INST_LOADER_WRAP_EN
            r_addra <= r_addra + 1'b1;
`else
            if (!w_last_addr) r_addra <= r_addra + 1'b1;
`endif
         end
      end
   end

   assign addra    = r_addra;
   assign dina     = r_dina;
   assign byte_cnt = r_byte_cnt;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: spec-level model compared every cycle plus directed literal checks.
// Build with INST_LOADER_WRAP_EN defined to exercise the wrapping variant.
module tb_inst_mem_loader;

   localparam int STAGE  = 4;
   localparam int ADDR_W = 2;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              Clk;
   logic              Rst;
   logic              Button;
   logic [7:0]        Switch;
   logic              wea;
   logic [ADDR_W-1:0] addra;
   logic [31:0]       dina;
   logic [1:0]        byte_cnt;
   logic              full;

   inst_mem_loader #(.STAGE(STAGE), .ADDR_W(ADDR_W)) dut (
      .Clk(Clk), .Rst(Rst), .Button(Button), .Switch(Switch),
      .wea(wea), .addra(addra), .dina(dina), .byte_cnt(byte_cnt), .full(full)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   // Model: button history, debounced level, bytes collected, words written.
   logic [STAGE-1:0] m_hist;
   logic             m_deb, m_deb_q, m_wr;
   logic [7:0]       m_bytes [4];
   int               m_nbytes;
   int               m_written;
   logic             m_full;
   int               exp_addr;
   logic [31:0]      exp_dina;

`ifdef INST_LOADER_WRAP_EN
   assign m_full   = 1'b0;
   assign exp_addr = m_written % DEPTH;
`else
   assign m_full   = (m_written >= DEPTH);
   assign exp_addr = m_full ? DEPTH - 1 : m_written;
`endif
   assign exp_dina = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};

   always @(posedge Clk) begin
      if (Rst) begin
         m_hist    <= '0;
         m_deb     <= 1'b0;
         m_deb_q   <= 1'b0;
         m_wr      <= 1'b0;
         m_nbytes  <= 0;
         m_written <= 0;
         for (int i = 0; i < 4; i++) m_bytes[i] <= 8'h00;
      end else begin
         m_hist <= {m_hist[STAGE-2:0], Button};
         if (&m_hist[STAGE-1:1]) m_deb <= 1'b1;
         else if (~|m_hist[STAGE-1:1]) m_deb <= 1'b0;
         m_deb_q <= m_deb;
         if (m_wr) begin
            m_wr      <= 1'b0;
            m_written <= m_written + 1;
         end else if (!m_full && m_deb && !m_deb_q) begin
            m_bytes[m_nbytes] <= Switch;
            if (m_nbytes == 3) begin
               m_nbytes <= 0;
               m_wr     <= 1'b1;
            end else begin
               m_nbytes <= m_nbytes + 1;
            end
         end
      end
   end

   logic        chk_en = 1'b0;
   int          wr_addr [$];
   logic [31:0] wr_data [$];

   always @(negedge Clk) begin
      if (chk_en) begin
         check("wea", {31'b0, wea}, {31'b0, m_wr});
         check("addra", 32'(addra), exp_addr);
         check("dina", dina, exp_dina);
         check("byte_cnt", 32'(byte_cnt), m_nbytes);
         check("full", {31'b0, full}, {31'b0, m_full});
         if (wea === 1'b1) begin
            wr_addr.push_back(int'(addra));
            wr_data.push_back(dina);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      Rst = 1'b1;
      tick(n);
      Rst = 1'b0;
   endtask

   task automatic press(input logic [7:0] v);
      Switch = v;
      Button = 1'b1;
      tick(8);
      Button = 1'b0;
      tick(8);
   endtask

   task automatic check_write(input string name, input int idx, input int a, input logic [31:0] d);
      if (wr_addr.size() > idx) begin
         check({name, "_addr"}, wr_addr[idx], a);
         check({name, "_data"}, wr_data[idx], d);
      end else begin
         check({name, "_present"}, wr_addr.size(), idx + 1);
      end
   endtask

   initial begin
      logic [31:0] e;
      Rst    = 1'b1;
      Button = 1'b1;
      Switch = 8'h5A;
      tick(1);
      chk_en = 1'b1;
      tick(2);
      check("rst_wea", {31'b0, wea}, 32'd0);
      check("rst_addra", 32'(addra), 32'd0);
      check("rst_dina", dina, 32'd0);
      check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
      check("rst_full", {31'b0, full}, 32'd0);

      // Button held through reset release: one press once the chain fills.
      Rst = 1'b0;
      tick(10);
      check("held_byte_cnt", 32'(byte_cnt), 32'd1);
      check("held_lane0", 32'(dina[7:0]), 32'h5A);
      Button = 1'b0;
      tick(8);
      check("held_single", 32'(byte_cnt), 32'd1);

      // Glitch of two samples is rejected, a long hold gives one capture.
      do_reset(1);
      Switch = 8'h3C;
      Button = 1'b1;
      tick(2);
      Button = 1'b0;
      tick(10);
      check("glitch_byte_cnt", 32'(byte_cnt), 32'd0);
      Button = 1'b1;
      tick(20);
      check("long_byte_cnt", 32'(byte_cnt), 32'd1);
      check("long_lane0", 32'(dina[7:0]), 32'h3C);
      Button = 1'b0;
      tick(8);
      check("long_no_write", wr_addr.size(), 0);

      // One full word.
      do_reset(1);
      press(8'h13); press(8'h00); press(8'h50); press(8'h00);
      check("word_count", wr_addr.size(), 1);
      check_write("word", 0, 0, 32'h0050_0013);
      check("word_addra", 32'(addra), 32'd1);
      check("word_byte_cnt", 32'(byte_cnt), 32'd0);

      // Reset in the middle of a word discards it.
      press(8'hAA); press(8'hBB);
      check("mid_byte_cnt_pre", 32'(byte_cnt), 32'd2);
      do_reset(1);
      check("mid_byte_cnt", 32'(byte_cnt), 32'd0);
      check("mid_addra", 32'(addra), 32'd0);
      check("mid_no_write", wr_addr.size(), 1);
      press(8'h11); press(8'h22); press(8'h33); press(8'h44);
      check_write("after_mid", 1, 0, 32'h4433_2211);

      // Fill every word, then one more.
      do_reset(1);
      for (int w = 0; w < DEPTH; w++)
         for (int b = 0; b < 4; b++) press(8'(16 * w + b));
      check("fill_count", wr_addr.size(), 2 + DEPTH);
      for (int w = 0; w < DEPTH; w++) begin
         e = {8'(16 * w + 3), 8'(16 * w + 2), 8'(16 * w + 1), 8'(16 * w)};
         check_write("fill", 2 + w, w, e);
      end
`ifdef INST_LOADER_WRAP_EN
      check("fill_full", {31'b0, full}, 32'd0);
      check("fill_addra", 32'(addra), 32'd0);
      press(8'hE0); press(8'hE1); press(8'hE2); press(8'hE3);
      check("wrap_count", wr_addr.size(), 3 + DEPTH);
      check_write("wrap", 2 + DEPTH, 0, 32'hE3E2_E1E0);
      check("wrap_full", {31'b0, full}, 32'd0);
`else
      check("fill_full", {31'b0, full}, 32'd1);
      check("fill_addra", 32'(addra), 32'(DEPTH - 1));
      press(8'hE0); press(8'hE1); press(8'hE2); press(8'hE3);
      check("sat_count", wr_addr.size(), 2 + DEPTH);
      check("sat_byte_cnt", 32'(byte_cnt), 32'd0);
      check("sat_full", {31'b0, full}, 32'd1);
`endif

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer side of the instruction memory: an operator enters a 32-bit instruction one byte at a time on 8 switches, confirming each byte with a push button.
- After four bytes the block issues a single-cycle write to the instruction block RAM port A (wea/addra/dina) and advances the word address.
- Sits beside the fetch/display logic and shares the same RAM port.
- Shares the same debounce style (shift chain with hysteresis) as the fetch step button.

Parameters:
- STAGE, 10: debounce chain length in clocks; minimum 3.
- ADDR_W, 6: word-address width; depth = 2**ADDR_W words.

Ports:
- Clk  in  1  system clock, all logic on posedge.
- Rst  in  1  synchronous, active-high reset.
- Button  in  1  raw, undebounced confirm button; active high.
- Switch  in  8  byte value to enter.
- wea  out  1  RAM write enable; one-cycle pulse.
- addra  out  ADDR_W  RAM word address (drive into RAM addra directly).
- dina  out  32  RAM write data.
- byte_cnt  out  2  bytes already captured in the current word (0..3).
- full  out  1  memory filled; further presses ignored.

Behaviour:
- Reset: Rst sampled high at a posedge clears every register.
  - Outputs: wea=0, addra=0, dina=0, byte_cnt=0, full=0.
  - Internals: debounce chain, debounced level deb, edge-detect delay and FSM (to COLLECT) all cleared.
  - Rst mid-word discards the partial word; no write is issued.
- Debounce:
  - Each clock, chain <= {chain[STAGE-2:0], Button}.
  - deb <= 1 if chain[STAGE-1:1] is all ones; deb <= 0 if it is all zeros; otherwise deb holds.
- Press pulse: press = deb & ~deb_q, where deb_q is deb delayed one clock.
  - Exactly one press per deb rising edge.
  - Button high for fewer than STAGE-1 consecutive samples never produces a press.
  - Release produces no press.
  - Button held through reset deassertion produces one press once the chain fills (deb resets to 0).
- FSM states: COLLECT, WRITE, FULL.
- COLLECT, on press:
  - Switch is latched into dina byte lane byte_cnt (little-endian; first byte goes to dina[7:0], fourth to dina[31:24]).
  - byte_cnt is incremented.
  - When byte_cnt==3 at the press: byte_cnt wraps to 0 and the FSM goes to WRITE.
- WRITE, exactly one cycle:
  - wea=1, with addra and dina stable and holding the completed word.
  - Next state: if addra==2**ADDR_W-1, go to FULL with addra unchanged; otherwise addra <= addra+1 and return to COLLECT.
  - A press pulse coincident with WRITE is dropped (not possible with STAGE>=3, but required anyway).
- FULL:
  - full=1, wea=0, presses ignored.
  - Only Rst leaves FULL.
- dina holds its last value between writes; untouched lanes keep stale bytes until overwritten.
- wea is never asserted outside WRITE.
- Latency: the fourth press is captured at posedge N; wea is high during the cycle after posedge N.

Optional Feature:
- Macro: INST_LOADER_WRAP_EN.
- Defined: WRITE at addra==2**ADDR_W-1 sets addra to 0 and returns to COLLECT. FULL is unreachable and full is tied 0; loading continues, overwriting from word 0.
- Undefined: behaviour exactly as specified above (saturate into FULL).

Test Plan:
- Reset values: assert Rst 3 cycles with Button high → all outputs 0. After release, hold Button → exactly one press; dina[7:0]=Switch and byte_cnt=1.
- Glitch rejection (STAGE=4): Button high for 2 clocks, then low → byte_cnt stays 0 and deb never rises. Button high for 20 clocks → byte_cnt=1 and exactly one capture.
- One word: Switch=0x13,0x00,0x50,0x00 on four clean presses → single-cycle wea=1 with addra=0 and dina=0x00500013. Afterwards addra=1 and byte_cnt=0.
- Reset mid-word: two presses (0xAA, 0xBB), then Rst one cycle → byte_cnt=0, addra=0, no wea. The next four presses write to address 0.
- Fill (ADDR_W=2): load 4 words → wea at addra 0,1,2,3, then full=1 and addra=3. A fifth word of presses gives no wea and byte_cnt stays 0.
- Same fill with INST_LOADER_WRAP_EN defined: fifth word written at addra=0 and full stays 0.
